instruction_fetch_unit: RTL and testbench

- Requester side of the instruction-cache interface.
- Generates sequential fetch addresses and issues them to the I-cache over a valid/ready request channel.
- Buffers returned instruction words in a small FIFO and presents them to decode with valid/ready.
- Handles PC redirects from execute by flushing buffered words and discarding responses still in flight.

---
 rtl/instruction_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to the I-cache and queues the returned words for decode.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall and dropped-response counters.
module instruction_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              icache_req_valid,
   input  logic              icache_req_ready,
   output logic [ADDR_W-1:0] icache_req_addr,
   input  logic              icache_resp_valid,
   input  logic [DATA_W-1:0] icache_resp_data,
   output logic              fetch_valid,
   input  logic              fetch_ready,
   output logic [DATA_W-1:0] fetch_instr,
   output logic [ADDR_W-1:0] fetch_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_dropped_resp
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

   typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

   // Valid/ready: a request transfers on icache_req_valid && icache_req_ready,
   // an instruction on fetch_valid && fetch_ready; responses are never stalled.
   state_t            state, next_state;
   logic              req_valid, next_req_valid;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  outstanding, next_outstanding;
   logic [CNT_W-1:0]  drop_cnt, next_drop;
   logic [CNT_W-1:0]  fifo_count, next_fifo_count;

   logic [ADDR_W-1:0] tag_mem [DEPTH];
   logic [PTR_W-1:0]  tag_wptr, tag_rptr;
   logic [ADDR_W-1:0] pc_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  fifo_wptr, fifo_rptr;

   logic req_fire, resp_fire, dropping, push, pop;
   logic unused_bits;

   assign unused_bits = ^redirect_pc[1:0];

   assign icache_req_valid = req_valid;
   assign icache_req_addr  = pc;
   assign fetch_valid      = (fifo_count != '0);
   assign fetch_instr      = data_mem[fifo_rptr];
   assign fetch_pc         = pc_mem[fifo_rptr];

   // A response with nothing outstanding is spurious and ignored entirely.
   assign req_fire  = req_valid && icache_req_ready;
   assign resp_fire = icache_resp_valid && (outstanding != '0);
   assign dropping  = (state == FLUSH) || redirect_valid;
   assign push      = resp_fire && !dropping;
   assign pop       = fetch_valid && fetch_ready;

   assign next_outstanding = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);
   assign next_fifo_count  = redirect_valid ? '0
                           : fifo_count + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      next_state = state;
      next_drop  = drop_cnt;
      if (state == FETCH) begin
         if (redirect_valid) begin
            next_drop = next_outstanding;
            if (next_outstanding != '0) next_state = FLUSH;
         end
      end else begin
         next_drop = drop_cnt - CNT_W'(resp_fire);
         if (next_drop == '0) next_state = FETCH;
      end
   end

   // Credit check on the post-edge counts keeps the registered valid exact.
   assign next_req_valid = (next_state == FETCH) &&
                           ((SUM_W'(next_outstanding) + SUM_W'(next_fifo_count)) < SUM_W'(DEPTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         req_valid   <= 1'b0;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         fifo_count  <= '0;
         tag_wptr    <= '0;
         tag_rptr    <= '0;
         fifo_wptr   <= '0;
         fifo_rptr   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_mem[i]  <= '0;
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         state       <= next_state;
         req_valid   <= next_req_valid;
         outstanding <= next_outstanding;
         drop_cnt    <= next_drop;
         fifo_count  <= next_fifo_count;

         if (redirect_valid) pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
         else if (req_fire)  pc <= pc + ADDR_W'(4);

         // Tags keep flowing during a flush so dropped responses stay aligned.
         if (req_fire) begin
            tag_mem[tag_wptr] <= pc;
            tag_wptr          <= tag_wptr + 1'b1;
         end
         if (resp_fire) tag_rptr <= tag_rptr + 1'b1;

         if (redirect_valid) begin
            fifo_wptr <= '0;
            fifo_rptr <= '0;
         end else begin
            if (push) begin
               pc_mem[fifo_wptr]   <= tag_mem[tag_rptr];
               data_mem[fifo_wptr] <= icache_resp_data;
               fifo_wptr           <= fifo_wptr + 1'b1;
            end
            if (pop) fifo_rptr <= fifo_rptr + 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic stall_evt, drop_evt;

   assign stall_evt = (req_valid && !icache_req_ready) ||
                      ((state == FETCH) &&
                       ((SUM_W'(outstanding) + SUM_W'(fifo_count)) >= SUM_W'(DEPTH)));
   assign drop_evt  = resp_fire && dropping;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cycles <= '0;
         perf_dropped_resp <= '0;
      end else begin
         if (stall_evt && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (drop_evt && (perf_dropped_resp != 32'hFFFF_FFFF))
            perf_dropped_resp <= perf_dropped_resp + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 1-cycle-latency in-order I-cache model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        icache_req_valid;
   logic        icache_req_ready;
   logic [31:0] icache_req_addr;
   logic        icache_resp_valid;
   logic [31:0] icache_resp_data;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_dropped_resp;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] req_log[$];
   logic [31:0] pend_q[$];
   logic [31:0] got_pc_q[$];
   logic [31:0] got_data_q[$];
   logic [31:0] exp_q[$];
   bit          resp_hold;

   instruction_fetch_unit dut (
      .clk               (clk),
      .reset             (reset),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .icache_req_valid  (icache_req_valid),
      .icache_req_ready  (icache_req_ready),
      .icache_req_addr   (icache_req_addr),
      .icache_resp_valid (icache_resp_valid),
      .icache_resp_data  (icache_resp_data),
      .fetch_valid       (fetch_valid),
      .fetch_ready       (fetch_ready),
      .fetch_instr       (fetch_instr),
      .fetch_pc          (fetch_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_dropped_resp (perf_dropped_resp)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'hC3C3_0000;
   endfunction

   // One clock: log handshakes seen before the edge, then present the next response.
   task automatic tick();
      if (icache_req_valid && icache_req_ready) begin
         req_log.push_back(icache_req_addr);
         pend_q.push_back(icache_req_addr);
      end
      if (fetch_valid && fetch_ready) begin
         got_pc_q.push_back(fetch_pc);
         got_data_q.push_back(fetch_instr);
      end
      @(posedge clk);
      @(negedge clk);
      if (!resp_hold && pend_q.size() > 0) begin
         icache_resp_valid = 1'b1;
         icache_resp_data  = data_of(pend_q.pop_front());
      end else begin
         icache_resp_valid = 1'b0;
         icache_resp_data  = '0;
      end
   endtask

   task automatic do_reset();
      reset             = 1'b0;
      redirect_valid    = 1'b0;
      redirect_pc       = '0;
      icache_req_ready  = 1'b0;
      icache_resp_valid = 1'b0;
      icache_resp_data  = '0;
      fetch_ready       = 1'b0;
      resp_hold         = 1'b0;
      pend_q.delete();
      req_log.delete();
      got_pc_q.delete();
      got_data_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0;
      icache_req_ready = 1'b1;
      fetch_ready = 1'b1;
      @(negedge clk);
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", icache_req_valid); end
      checks++; if (icache_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 00000000", icache_req_addr); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid); end
      checks++; if (fetch_instr !== 32'h0) begin errors++; $display("FAIL reset_fetch_instr: got %h expected 00000000", fetch_instr); end
      checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc: got %h expected 00000000", fetch_pc); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall_cycles); end
`endif
      // Asynchronous reset in the middle of streaming.
      do_reset();
      icache_req_ready = 1'b1;
      fetch_ready = 1'b1;
      repeat (6) tick();
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %b expected 1", fetch_valid); end
      #2 reset = 1'b0;
      #1;
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL midreset_req_valid: got %b expected 0", icache_req_valid); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL midreset_fetch_valid: got %b expected 0", fetch_valid); end
      checks++; if (icache_req_addr !== 32'h0) begin errors++; $display("FAIL midreset_addr: got %h expected 00000000", icache_req_addr); end
   endtask

   task automatic test_sequential();
      do_reset();
      icache_req_ready = 1'b1;
      fetch_ready = 1'b1;
      repeat (12) tick();
      checks++; if (req_log.size() != 11) begin errors++; $display("FAIL seq_req_count: got %0d expected 11", req_log.size()); end
      for (int i = 0; i < req_log.size() && i < 11; i++) begin
         checks++; if (req_log[i] !== 32'(i * 4)) begin errors++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(i * 4)); end
      end
      checks++; if (got_pc_q.size() != 9) begin errors++; $display("FAIL seq_pop_count: got %0d expected 9", got_pc_q.size()); end
      for (int i = 0; i < got_pc_q.size() && i < 9; i++) begin
         checks++; if (got_pc_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL seq_fetch_pc[%0d]: got %h expected %h", i, got_pc_q[i], 32'(i * 4)); end
         checks++; if (got_data_q[i] !== data_of(32'(i * 4))) begin errors++; $display("FAIL seq_fetch_instr[%0d]: got %h expected %h", i, got_data_q[i], data_of(32'(i * 4))); end
      end
   endtask

   task automatic test_fifo_full();
      do_reset();
      icache_req_ready = 1'b1;
      fetch_ready = 1'b0;
      repeat (10) tick();
      checks++; if (req_log.size() != 4) begin errors++; $display("FAIL full_req_count: got %0d expected 4", req_log.size()); end
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid: got %b expected 0", icache_req_valid); end
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL full_fetch_valid: got %b expected 1", fetch_valid); end
      checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc: got %h expected 00000000", fetch_pc); end
      checks++; if (fetch_instr !== data_of(32'h0)) begin errors++; $display("FAIL full_head_instr: got %h expected %h", fetch_instr, data_of(32'h0)); end
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      repeat (6) tick();
      checks++; if (req_log.size() != 5) begin errors++; $display("FAIL full_refill_count: got %0d expected 5", req_log.size()); end
      if (req_log.size() >= 5) begin
         checks++; if (req_log[4] !== 32'h10) begin errors++; $display("FAIL full_refill_addr: got %h expected 00000010", req_log[4]); end
      end
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL full_refill_valid: got %b expected 0", icache_req_valid); end
      checks++; if (fetch_pc !== 32'h4) begin errors++; $display("FAIL full_new_head: got %h expected 00000004", fetch_pc); end
   endtask

   task automatic test_req_stall();
      do_reset();
      fetch_ready = 1'b1;
      icache_req_ready = 1'b1;
      repeat (5) tick();
      icache_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (icache_req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, icache_req_valid); end
         checks++; if (icache_req_addr !== 32'h10) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 00000010", i, icache_req_addr); end
         tick();
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_stall_cycles !== 32'd5) begin errors++; $display("FAIL stall_perf: got %0d expected 5", perf_stall_cycles); end
`endif
      icache_req_ready = 1'b1;
      tick();
      icache_req_ready = 1'b0;
      tick();
      checks++; if (req_log.size() != 5) begin errors++; $display("FAIL stall_req_count: got %0d expected 5", req_log.size()); end
      if (req_log.size() >= 5) begin
         checks++; if (req_log[4] !== 32'h10) begin errors++; $display("FAIL stall_issued: got %h expected 00000010", req_log[4]); end
      end
      checks++; if (icache_req_addr !== 32'h14) begin errors++; $display("FAIL stall_next_addr: got %h expected 00000014", icache_req_addr); end
   endtask

   task automatic test_redirect_flush();
      do_reset();
      fetch_ready = 1'b1;
      resp_hold = 1'b1;
      icache_req_ready = 1'b1;
      repeat (4) tick();
      icache_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL flush_req_valid: got %b expected 0", icache_req_valid); end
      checks++; if (icache_req_addr !== 32'h100) begin errors++; $display("FAIL flush_addr: got %h expected 00000100", icache_req_addr); end
      resp_hold = 1'b0;
      icache_req_ready = 1'b1;
      repeat (12) tick();
      exp_q = '{32'h0, 32'h4, 32'h8, 32'h100};
      checks++; if (req_log.size() < 4) begin errors++; $display("FAIL flush_req_count: got %0d expected >=4", req_log.size()); end
      for (int i = 0; i < 4 && i < req_log.size(); i++) begin
         checks++; if (req_log[i] !== exp_q[i]) begin errors++; $display("FAIL flush_req_addr[%0d]: got %h expected %h", i, req_log[i], exp_q[i]); end
      end
      checks++;
      if (got_pc_q.size() < 1) begin
         errors++; $display("FAIL flush_first_pc: got no instruction expected 00000100");
      end else if (got_pc_q[0] !== 32'h100 || got_data_q[0] !== data_of(32'h100)) begin
         errors++; $display("FAIL flush_first_pc: got %h/%h expected 00000100/%h", got_pc_q[0], got_data_q[0], data_of(32'h100));
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_dropped_resp !== 32'd3) begin errors++; $display("FAIL flush_perf_dropped: got %0d expected 3", perf_dropped_resp); end
`endif
   endtask

   task automatic test_redirect_idle();
      do_reset();
      fetch_ready = 1'b1;
      repeat (3) tick();
      checks++; if (icache_req_valid !== 1'b1) begin errors++; $display("FAIL idle_valid: got %b expected 1", icache_req_valid); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect_valid = 1'b0;
      checks++; if (icache_req_addr !== 32'h200) begin errors++; $display("FAIL idle_redirect_addr: got %h expected 00000200", icache_req_addr); end
      checks++; if (icache_req_valid !== 1'b1) begin errors++; $display("FAIL idle_stay_fetch: got %b expected 1", icache_req_valid); end
      icache_req_ready = 1'b1;
      tick();
      icache_req_ready = 1'b0;
      repeat (4) tick();
      checks++;
      if (got_pc_q.size() != 1) begin
         errors++; $display("FAIL idle_pop_count: got %0d expected 1", got_pc_q.size());
      end else if (got_pc_q[0] !== 32'h200) begin
         errors++; $display("FAIL idle_pop_count: got pc %h expected 00000200", got_pc_q[0]);
      end
   endtask

   task automatic test_redirect_coincide();
      do_reset();
      fetch_ready = 1'b0;
      resp_hold = 1'b1;
      icache_req_ready = 1'b1;
      repeat (2) tick();
      resp_hold = 1'b0;
      tick();
      // Redirect edge: request for 0x8 accepted and response for 0x0 returned together.
      checks++; if (icache_resp_valid !== 1'b1 || icache_req_valid !== 1'b1) begin errors++; $display("FAIL coin_setup: got resp %b req %b expected 1 1", icache_resp_valid, icache_req_valid); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect_valid = 1'b0;
      fetch_ready = 1'b1;
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL coin_flush_valid: got %b expected 0", icache_req_valid); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL coin_fetch_valid: got %b expected 0", fetch_valid); end
      tick();
      checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL coin_still_flushing: got %b expected 0", icache_req_valid); end
      repeat (10) tick();
      checks++;
      if (req_log.size() < 4) begin
         errors++; $display("FAIL coin_req_after: got %0d requests expected >=4", req_log.size());
      end else if (req_log[2] !== 32'h8 || req_log[3] !== 32'h300) begin
         errors++; $display("FAIL coin_req_after: got %h,%h expected 00000008,00000300", req_log[2], req_log[3]);
      end
      checks++;
      if (got_pc_q.size() < 2) begin
         errors++; $display("FAIL coin_first_pcs: got %0d pops expected >=2", got_pc_q.size());
      end else if (got_pc_q[0] !== 32'h300 || got_pc_q[1] !== 32'h304 || got_data_q[0] !== data_of(32'h300)) begin
         errors++; $display("FAIL coin_first_pcs: got %h,%h expected 00000300,00000304", got_pc_q[0], got_pc_q[1]);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_dropped_resp !== 32'd3) begin errors++; $display("FAIL coin_perf_dropped: got %0d expected 3", perf_dropped_resp); end
`endif
   endtask

   task automatic test_spurious_resp();
      do_reset();
      fetch_ready = 1'b1;
      repeat (2) tick();
      icache_resp_valid = 1'b1;
      icache_resp_data = 32'hBAD0_BAD0;
      tick();
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL spur_fetch_valid: got %b expected 0", fetch_valid); end
      checks++; if (icache_req_valid !== 1'b1) begin errors++; $display("FAIL spur_credit: got %b expected 1", icache_req_valid); end
      icache_req_ready = 1'b1;
      repeat (5) tick();
      checks++;
      if (got_pc_q.size() < 1) begin
         errors++; $display("FAIL spur_first_pc: got no instruction expected 00000000");
      end else if (got_pc_q[0] !== 32'h0 || got_data_q[0] !== data_of(32'h0)) begin
         errors++; $display("FAIL spur_first_pc: got %h/%h expected 00000000/%h", got_pc_q[0], got_data_q[0], data_of(32'h0));
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_fifo_full();
      test_req_stall();
      test_redirect_flush();
      test_redirect_idle();
      test_redirect_coincide();
      test_spurious_resp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
